aq_axi_lite_local_bridge: RTL

AXI4-Lite slave that converts CPU register accesses into single AQ_LOCAL bus transactions. It sits directly upstream of AQ_LOCAL register slaves such as the frequency-measure control block and drives their CS/RNW/ADDR/BE/WDATA. It collects ACK/RDATA from the slave and returns the AXI B or R response. One transaction is outstanding at a time, and a timeout guard prevents a dead slave from hanging the bus.

---
 rtl/aq_axi_lite_local_bridge.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/aq_axi_lite_local_bridge.sv
// ---------------------------------------------------------------------------
// aq_axi_lite_local_bridge
//
// Purpose:
//   AXI4-Lite slave that turns each CPU register access into exactly one
//   AQ_LOCAL bus transaction. Only one access is in flight at a time. A
//   timeout guard ends the access with SLVERR when the local slave never
//   acknowledges.
//
// Parameters:
//   TIMEOUT : AQ_LOCAL_CLK cycles to wait for AQ_LOCAL_ACK (2..65535)
//   TMO_W   : timeout counter width, 2**TMO_W > TIMEOUT
//
// Ports:
//   AQ_LOCAL_CLK, RST       : single clock, asynchronous active-high reset
//   S_AXI_AW*/W*/B*         : AXI4-Lite write address / data / response
//   S_AXI_AR*/R*            : AXI4-Lite read address / data
//   AQ_LOCAL_CS/RNW/ADDR/BE/WDATA : registered request towards the slave
//   AQ_LOCAL_ACK/RDATA      : slave acknowledge and read data (ACK cycle)
// ---------------------------------------------------------------------------
module aq_axi_lite_local_bridge #(
  parameter int TIMEOUT = 256,
  parameter int TMO_W   = 16
) (
  input  logic        AQ_LOCAL_CLK,
  input  logic        RST,

  input  logic [31:0] S_AXI_AWADDR,
  input  logic        S_AXI_AWVALID,
  output logic        S_AXI_AWREADY,
  input  logic [31:0] S_AXI_WDATA,
  input  logic [3:0]  S_AXI_WSTRB,
  input  logic        S_AXI_WVALID,
  output logic        S_AXI_WREADY,
  output logic [1:0]  S_AXI_BRESP,
  output logic        S_AXI_BVALID,
  input  logic        S_AXI_BREADY,

  input  logic [31:0] S_AXI_ARADDR,
  input  logic        S_AXI_ARVALID,
  output logic        S_AXI_ARREADY,
  output logic [31:0] S_AXI_RDATA,
  output logic [1:0]  S_AXI_RRESP,
  output logic        S_AXI_RVALID,
  input  logic        S_AXI_RREADY,

  output logic        AQ_LOCAL_CS,
  output logic        AQ_LOCAL_RNW,
  output logic [31:0] AQ_LOCAL_ADDR,
  output logic [3:0]  AQ_LOCAL_BE,
  output logic [31:0] AQ_LOCAL_WDATA,
  input  logic        AQ_LOCAL_ACK,
  input  logic [31:0] AQ_LOCAL_RDATA
);

  localparam logic [1:0]       RESP_OKAY   = 2'b00;
  localparam logic [1:0]       RESP_SLVERR = 2'b10;
  localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WREQ  = 3'd1,
    WRESP = 3'd2,
    RREQ  = 3'd3,
    RRESP = 3'd4
  } state_t;

  state_t            state_q;
  logic [TMO_W-1:0]  tmo_cnt_q;
  logic              cs_q;
  logic              rnw_q;
  logic [31:0]       addr_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;
  logic              bvalid_q;
  logic [1:0]        bresp_q;
  logic              rvalid_q;
  logic [1:0]        rresp_q;
  logic [31:0]       rdata_q;

  logic              aw_hs;
  logic              ar_hs;

  // AW and W are only taken as a pair; a pending write blocks the read.
  assign aw_hs = (state_q == IDLE) && S_AXI_AWVALID && S_AXI_WVALID;
  assign ar_hs = (state_q == IDLE) && S_AXI_ARVALID &&
                 !(S_AXI_AWVALID && S_AXI_WVALID);

  assign S_AXI_AWREADY = aw_hs;
  assign S_AXI_WREADY  = aw_hs;
  assign S_AXI_ARREADY = ar_hs;

  always_ff @(posedge AQ_LOCAL_CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      tmo_cnt_q <= '0;
      cs_q      <= 1'b0;
      rnw_q     <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (aw_hs) begin
            addr_q    <= S_AXI_AWADDR;
            wdata_q   <= S_AXI_WDATA;
            be_q      <= S_AXI_WSTRB;
            rnw_q     <= 1'b0;
            cs_q      <= 1'b1;
            tmo_cnt_q <= '0;
            state_q   <= WREQ;
          end else if (ar_hs) begin
            addr_q    <= S_AXI_ARADDR;
            be_q      <= 4'hF;
            rnw_q     <= 1'b1;
            cs_q      <= 1'b1;
            tmo_cnt_q <= '0;
            state_q   <= RREQ;
          end
        end

        WREQ: begin
          // ACK on the terminal count still wins and yields OKAY.
          if (AQ_LOCAL_ACK) begin
            cs_q     <= 1'b0;
            bresp_q  <= RESP_OKAY;
            bvalid_q <= 1'b1;
            state_q  <= WRESP;
          end else if (tmo_cnt_q == TMO_LAST) begin
            cs_q     <= 1'b0;
            bresp_q  <= RESP_SLVERR;
            bvalid_q <= 1'b1;
            state_q  <= WRESP;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
          end
        end

        RREQ: begin
          if (AQ_LOCAL_ACK) begin
            cs_q     <= 1'b0;
            rdata_q  <= AQ_LOCAL_RDATA;
            rresp_q  <= RESP_OKAY;
            rvalid_q <= 1'b1;
            state_q  <= RRESP;
          end else if (tmo_cnt_q == TMO_LAST) begin
            cs_q     <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_SLVERR;
            rvalid_q <= 1'b1;
            state_q  <= RRESP;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
          end
        end

        // ACK is deliberately ignored here: a registered slave raises one
        // more ACK because CS was still high in its ACK cycle.
        WRESP: begin
          if (S_AXI_BREADY) begin
            bvalid_q <= 1'b0;
            state_q  <= IDLE;
          end
        end

        RRESP: begin
          if (S_AXI_RREADY) begin
            rvalid_q <= 1'b0;
            state_q  <= IDLE;
          end
        end

        default: begin
          cs_q     <= 1'b0;
          bvalid_q <= 1'b0;
          rvalid_q <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign S_AXI_BVALID   = bvalid_q;
  assign S_AXI_BRESP    = bresp_q;
  assign S_AXI_RVALID   = rvalid_q;
  assign S_AXI_RRESP    = rresp_q;
  assign S_AXI_RDATA    = rdata_q;
  assign AQ_LOCAL_CS    = cs_q;
  assign AQ_LOCAL_RNW   = rnw_q;
  assign AQ_LOCAL_ADDR  = addr_q;
  assign AQ_LOCAL_BE    = be_q;
  assign AQ_LOCAL_WDATA = wdata_q;

endmodule
